// File: rtl/uart_regif_pkg.sv
// Shared constants for the uart APB register front end: register map,
// STATUS/CTRL bit positions, FSM encoding and the reset baud divider.
package uart_regif_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_BAUD   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STATUS_RX_EMPTY_BIT = 0;
    localparam int STATUS_TX_FULL_BIT  = 1;
    localparam int STATUS_TX_OVF_BIT   = 2;
    localparam int STATUS_RX_UDF_BIT   = 3;

    localparam int CTRL_RX_IRQ_EN_BIT  = 0;
    localparam int CTRL_TX_IRQ_EN_BIT  = 1;
    localparam int CTRL_ERR_IRQ_EN_BIT = 2;
    localparam int CTRL_W              = 3;

    // 100 MHz clock, 9600 baud, 16x oversampling
    localparam int TIMER_RST_DEFAULT = 650;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_DONE = 1'b1
    } regif_state_e;

endpackage

// File: rtl/uart_apb_regif.sv
// APB register front end for the uart core: DATA/STATUS/BAUD/CTRL registers.
// Define UART_REGIF_PSLVERR_EN to report error conditions on pslverr.
module uart_apb_regif
    import uart_regif_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TIMER_W   = 11,
    parameter int TIMER_RST = TIMER_RST_DEFAULT,
    parameter int PDATA_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [1:0]         paddr,
    input  logic [PDATA_W-1:0] pwdata,
    output logic [PDATA_W-1:0] prdata,
    output logic               pready,
    output logic               pslverr,
    output logic [DATA_W-1:0]  w_data,
    output logic               wr_uart,
    input  logic               tx_full,
    input  logic [DATA_W-1:0]  r_data,
    output logic               rd_uart,
    input  logic               rx_empty,
    output logic [TIMER_W-1:0] timer_final_value,
    output logic               irq
);

    regif_state_e       state_q, state_d;
    logic [PDATA_W-1:0] prdata_q;
    logic               rd_err_q;
    logic [TIMER_W-1:0] baud_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic               tx_ovf_q, rx_udf_q;

    logic               access, idle_access, data_rd_start;
    logic               data_wr, status_wr, baud_wr, ctrl_wr;
    logic [TIMER_W-1:0] baud_wdata;
    logic               baud_zero;
    logic               tx_ovf_set, tx_ovf_clr, rx_udf_set, rx_udf_clr;
    logic [PDATA_W-1:0] read_data, prdata_c;
    logic               pready_c, err_c;
    logic               unused_pwdata;

    // Side effects only happen in the first access cycle seen from IDLE
    assign access        = psel & penable;
    assign idle_access   = access & (state_q == ST_IDLE);
    assign data_rd_start = idle_access & ~pwrite & (paddr == ADDR_DATA);
    assign data_wr       = idle_access & pwrite & (paddr == ADDR_DATA);
    assign status_wr     = idle_access & pwrite & (paddr == ADDR_STATUS);
    assign baud_wr       = idle_access & pwrite & (paddr == ADDR_BAUD);
    assign ctrl_wr       = idle_access & pwrite & (paddr == ADDR_CTRL);

    assign baud_wdata    = pwdata[TIMER_W-1:0];
    assign baud_zero     = (baud_wdata == '0);

    assign tx_ovf_set    = data_wr & tx_full;
    assign rx_udf_set    = data_rd_start & rx_empty;
    assign tx_ovf_clr    = status_wr & pwdata[STATUS_TX_OVF_BIT];
    assign rx_udf_clr    = status_wr & pwdata[STATUS_RX_UDF_BIT];

    assign unused_pwdata = ^pwdata;

    always_comb begin
        read_data = '0;
        case (paddr)
            ADDR_STATUS: begin
                read_data[STATUS_RX_EMPTY_BIT] = rx_empty;
                read_data[STATUS_TX_FULL_BIT]  = tx_full;
                read_data[STATUS_TX_OVF_BIT]   = tx_ovf_q;
                read_data[STATUS_RX_UDF_BIT]   = rx_udf_q;
            end
            ADDR_BAUD: read_data[TIMER_W-1:0] = baud_q;
            ADDR_CTRL: read_data[CTRL_W-1:0]  = ctrl_q;
            default:   read_data = '0;
        endcase
    end

    // DATA reads take one wait state so the FIFO head is captured before the pop
    always_comb begin
        state_d  = state_q;
        pready_c = 1'b0;
        prdata_c = '0;
        err_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (data_rd_start) begin
                        state_d = ST_RD_DONE;
                    end else begin
                        pready_c = 1'b1;
                        if (!pwrite) begin
                            prdata_c = read_data;
                        end
                        err_c = tx_ovf_set | (baud_wr & baud_zero);
                    end
                end
            end
            ST_RD_DONE: begin
                pready_c = 1'b1;
                prdata_c = prdata_q;
                err_c    = rd_err_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset kills any in-flight completion immediately, not at the next edge
    assign pready = reset_n & pready_c;
    assign prdata = reset_n ? prdata_c : '0;

`ifdef UART_REGIF_PSLVERR_EN
    assign pslverr = reset_n & err_c;
`else
    logic unused_err;
    assign unused_err = err_c;
    assign pslverr    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            prdata_q <= '0;
            rd_err_q <= 1'b0;
            rd_uart  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_uart <= data_rd_start & ~rx_empty;
            if (data_rd_start) begin
                prdata_q <= rx_empty ? '0 : PDATA_W'(r_data);
                rd_err_q <= rx_empty;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_data  <= '0;
            wr_uart <= 1'b0;
            baud_q  <= TIMER_W'(TIMER_RST);
            ctrl_q  <= '0;
        end else begin
            wr_uart <= data_wr & ~tx_full;
            if (data_wr && !tx_full) begin
                w_data <= pwdata[DATA_W-1:0];
            end
            if (baud_wr && !baud_zero) begin
                baud_q <= baud_wdata;
            end
            if (ctrl_wr) begin
                ctrl_q <= pwdata[CTRL_W-1:0];
            end
        end
    end

    // Sticky error flags: a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (tx_ovf_set) begin
                tx_ovf_q <= 1'b1;
            end else if (tx_ovf_clr) begin
                tx_ovf_q <= 1'b0;
            end
            if (rx_udf_set) begin
                rx_udf_q <= 1'b1;
            end else if (rx_udf_clr) begin
                rx_udf_q <= 1'b0;
            end
            irq <= (ctrl_q[CTRL_RX_IRQ_EN_BIT] & ~rx_empty)
                 | (ctrl_q[CTRL_TX_IRQ_EN_BIT] & ~tx_full)
                 | (ctrl_q[CTRL_ERR_IRQ_EN_BIT] & (tx_ovf_q | rx_udf_q));
        end
    end

    assign timer_final_value = baud_q;

endmodule
